// File: rtl/user_input_conditioner_if.sv
// Signal bundle between the raw DE0 switch/button pins and the conditioned game-side outputs.
// The master drives the raw pins; the slave (the conditioner) returns the clean signals.
interface user_input_conditioner_if #(
  parameter int unsigned SW_WIDTH  = 8,
  parameter int unsigned BTN_COUNT = 3
);
  logic [SW_WIDTH-1:0]  sw_raw;
  logic [BTN_COUNT-1:0] button_n_raw;
  logic [SW_WIDTH-1:0]  sw_stable;
  logic [BTN_COUNT-1:0] button_level;
  logic [BTN_COUNT-1:0] button_press;
  logic [SW_WIDTH-1:0]  guess;
  logic                 guess_valid;

  modport master (
    output sw_raw,
    output button_n_raw,
    input  sw_stable,
    input  button_level,
    input  button_press,
    input  guess,
    input  guess_valid
  );

  modport slave (
    input  sw_raw,
    input  button_n_raw,
    output sw_stable,
    output button_level,
    output button_press,
    output guess,
    output guess_valid
  );
endinterface

// File: rtl/user_input_conditioner.sv
// Input stage for Flippin' Bits: synchronises and debounces switches and push-buttons,
// emits press pulses and latches the player's guess on a BUTTON[0] submit.
module user_input_conditioner #(
  parameter int unsigned SW_WIDTH        = 8,
  parameter int unsigned BTN_COUNT       = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_WIDTH       = 19
) (
  input logic                    clock,
  input logic                    reset,
  user_input_conditioner_if.slave io
);

  localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [SW_WIDTH-1:0]  sw_q1, sw_q2;
  logic [BTN_COUNT-1:0] btn_n_q1, btn_n_q2, btn_s;

  logic [BTN_COUNT-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [BTN_COUNT-1:0] level_q, level_d, press_q, press_d;

  logic [CNT_WIDTH-1:0] swc_q, swc_d;
  logic [SW_WIDTH-1:0]  sw_stable_q, sw_stable_d;
  logic [SW_WIDTH-1:0]  guess_q, guess_d;
  logic                 guess_valid_q, guess_valid_d;

  // Button sync stages idle high so a held button after reset is seen as a fresh press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_q1    <= '0;
      sw_q2    <= '0;
      btn_n_q1 <= '1;
      btn_n_q2 <= '1;
    end else begin
      sw_q1    <= io.sw_raw;
      sw_q2    <= sw_q1;
      btn_n_q1 <= io.button_n_raw;
      btn_n_q2 <= btn_n_q1;
    end
  end

  assign btn_s = ~btn_n_q2;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = '0;
    for (int i = 0; i < int'(BTN_COUNT); i++) begin
      if (btn_s[i] != level_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          level_d[i] = btn_s[i];
          press_d[i] = btn_s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // sw_q1 is next cycle's sw_s, so comparing it with sw_q2 makes swc read 0 in the very
  // cycle sw_s differs from its previous value.
  always_comb begin
    swc_d = swc_q;
    if (sw_q1 != sw_q2) begin
      swc_d = '0;
    end else if (swc_q != CntMax) begin
      swc_d = swc_q + 1'b1;
    end
  end

  always_comb begin
    sw_stable_d = sw_stable_q;
    if (swc_q == CntMax) begin
      sw_stable_d = sw_q2;
    end
  end

  // Capture the press-cycle sw_stable; later switch motion cannot leak into the guess.
  always_comb begin
    guess_d       = guess_q;
    guess_valid_d = press_q[0];
    if (press_q[0]) begin
      guess_d = sw_stable_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      level_q       <= '0;
      press_q       <= '0;
      swc_q         <= '0;
      sw_stable_q   <= '0;
      guess_q       <= '0;
      guess_valid_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      level_q       <= level_d;
      press_q       <= press_d;
      swc_q         <= swc_d;
      sw_stable_q   <= sw_stable_d;
      guess_q       <= guess_d;
      guess_valid_q <= guess_valid_d;
    end
  end

  assign io.sw_stable    = sw_stable_q;
  assign io.button_level = level_q;
  assign io.button_press = press_q;
  assign io.guess        = guess_q;
  assign io.guess_valid  = guess_valid_q;

endmodule

// File: tb/tb_user_input_conditioner.sv
// Directed bench for user_input_conditioner with DEBOUNCE_CYCLES = 4.
// Inputs change 1 ns after a rising edge; outputs are sampled at that same point.
module tb_user_input_conditioner;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   npulse;
  logic [2:0] seen;
  logic       flag;

  user_input_conditioner_if #(.SW_WIDTH(8), .BTN_COUNT(3)) uic_if ();

  user_input_conditioner #(
    .SW_WIDTH       (8),
    .BTN_COUNT      (3),
    .DEBOUNCE_CYCLES(4),
    .CNT_WIDTH      (19)
  ) dut (
    .clock(clock),
    .reset(reset),
    .io   (uic_if)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // 1: reset with switches at A5, buttons idle
    uic_if.sw_raw       = 8'hA5;
    uic_if.button_n_raw = 3'b111;
    tick(); tick(); tick();
    chk("rst_sw_stable", 32'(uic_if.sw_stable), 32'h00);
    chk("rst_level", 32'(uic_if.button_level), 32'h0);
    chk("rst_press", 32'(uic_if.button_press), 32'h0);
    chk("rst_guess", 32'(uic_if.guess), 32'h00);
    chk("rst_valid", 32'(uic_if.guess_valid), 32'h0);
    reset = 1'b0;
    seen = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen |= uic_if.button_press;
    end
    chk("sw_after_release", 32'(uic_if.sw_stable), 32'hA5);
    chk("no_press_after_release", 32'(seen), 32'h0);

    // 2: submit with button 0
    uic_if.button_n_raw = 3'b110;
    for (int i = 0; i < 5; i++) tick();
    chk("b0_press_early", 32'(uic_if.button_press), 32'h0);
    tick();
    chk("b0_press", 32'(uic_if.button_press), 32'h1);
    chk("b0_level", 32'(uic_if.button_level), 32'h1);
    chk("b0_valid_same_cycle", 32'(uic_if.guess_valid), 32'h0);
    tick();
    chk("b0_press_cleared", 32'(uic_if.button_press), 32'h0);
    chk("guess_a5", 32'(uic_if.guess), 32'hA5);
    chk("valid_a5", 32'(uic_if.guess_valid), 32'h1);
    tick();
    chk("valid_one_cycle", 32'(uic_if.guess_valid), 32'h0);
    uic_if.button_n_raw = 3'b111;
    seen = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen |= uic_if.button_press;
    end
    chk("release_no_pulse", 32'(seen), 32'h0);
    chk("b0_released", 32'(uic_if.button_level), 32'h0);

    // 3: glitch of 3 cycles on button 1, then a 4-cycle press
    uic_if.button_n_raw = 3'b101;
    seen = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen |= uic_if.button_press;
    end
    uic_if.button_n_raw = 3'b111;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen |= uic_if.button_press;
    end
    chk("glitch_no_pulse", 32'(seen), 32'h0);
    chk("glitch_no_level", 32'(uic_if.button_level), 32'h0);
    uic_if.button_n_raw = 3'b101;
    npulse = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      npulse += int'(uic_if.button_press[1]);
    end
    uic_if.button_n_raw = 3'b111;
    for (int i = 0; i < 10; i++) begin
      tick();
      npulse += int'(uic_if.button_press[1]);
    end
    chk("four_cycle_one_pulse", 32'(npulse), 32'd1);
    chk("four_cycle_released", 32'(uic_if.button_level), 32'h0);

    // 4: buttons 1 and 2 together
    uic_if.button_n_raw = 3'b001;
    for (int i = 0; i < 5; i++) tick();
    chk("dual_press_early", 32'(uic_if.button_press), 32'h0);
    tick();
    chk("dual_press", 32'(uic_if.button_press), 32'h6);
    chk("dual_level", 32'(uic_if.button_level), 32'h6);
    tick();
    chk("dual_press_cleared", 32'(uic_if.button_press), 32'h0);
    chk("dual_no_valid", 32'(uic_if.guess_valid), 32'h0);
    uic_if.button_n_raw = 3'b111;
    for (int i = 0; i < 12; i++) tick();

    // 5: switch bounce then settle at 3C, then submit while switches move
    flag = 1'b1;
    for (int i = 0; i < 10; i++) begin
      uic_if.sw_raw = i[0] ? 8'hF0 : 8'h0F;
      tick();
      flag &= (uic_if.sw_stable == 8'hA5);
      tick();
      flag &= (uic_if.sw_stable == 8'hA5);
    end
    chk("bounce_held", 32'(flag), 32'h1);
    uic_if.sw_raw = 8'h3C;
    for (int i = 0; i < 5; i++) tick();
    chk("settle_not_yet", 32'(uic_if.sw_stable), 32'hA5);
    tick();
    chk("settle_3c", 32'(uic_if.sw_stable), 32'h3C);
    uic_if.button_n_raw = 3'b110;
    for (int i = 0; i < 4; i++) tick();
    uic_if.sw_raw = 8'h00;
    tick(); tick();
    chk("submit_press", 32'(uic_if.button_press), 32'h1);
    tick();
    chk("guess_3c", 32'(uic_if.guess), 32'h3C);
    chk("valid_3c", 32'(uic_if.guess_valid), 32'h1);
    uic_if.button_n_raw = 3'b111;
    for (int i = 0; i < 12; i++) tick();
    chk("guess_held", 32'(uic_if.guess), 32'h3C);
    chk("sw_moved_to_00", 32'(uic_if.sw_stable), 32'h00);

    // 6: reset in the middle of a button-2 debounce
    uic_if.button_n_raw = 3'b011;
    tick(); tick(); tick();
    #1 reset = 1'b1;
    #1;
    chk("midrst_guess", 32'(uic_if.guess), 32'h00);
    chk("midrst_level", 32'(uic_if.button_level), 32'h0);
    @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("postrst_press_early", 32'(uic_if.button_press), 32'h0);
    tick();
    chk("postrst_press", 32'(uic_if.button_press), 32'h4);
    chk("postrst_level", 32'(uic_if.button_level), 32'h4);
    tick();
    chk("postrst_press_cleared", 32'(uic_if.button_press), 32'h0);
    uic_if.button_n_raw = 3'b111;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
